// File: rtl/regfile_write_sequencer.sv
// Register file writer: merges pipeline, multdiv and exception writebacks.
// Ports: clock/ctrl_reset, pipe_*, md_* (valid/ready), exc_*, regfile-side outputs, pending_mask.
module regfile_write_sequencer #(
   parameter int         DEPTH   = 2,
   parameter logic [4:0] RSTATUS = 5'd31
) (
   input  logic        clock,
   input  logic        ctrl_reset,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   input  logic        md_valid,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_data,
   output logic        md_ready,
   input  logic        exc_valid,
   input  logic [31:0] exc_code,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        rs_write,
   output logic [31:0] rs_writeData,
   output logic [31:0] pending_mask
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [4:0]       rd_q   [DEPTH];
   logic [31:0]      dat_q  [DEPTH];
   logic [DEPTH-1:0] live_q, live_k, live_d;
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic        we_q, we_d;
   logic [4:0]  wreg_q, wreg_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rs_q;
   logic [31:0] rsd_q, rsd_d;
   logic [31:0] pm_q, pm_d;

   logic pipe_wr, md_fire, fifo_empty;
   logic head_live, head_dead, bypass, md_drop;
   logic push, pop;
   logic [4:0] rd_n;

   assign md_ready = (count_q != CW'(DEPTH));

   always_comb begin
      pipe_wr    = pipe_we && (pipe_rd != 5'd0);
      md_fire    = md_valid && md_ready;
      fifo_empty = (count_q == '0);

      // A pipeline write is younger than every buffered result, and an
      // exception owns $rstatus; matching entries become dead in place.
      live_k = live_q;
      for (int i = 0; i < DEPTH; i++) begin
         if ((pipe_wr && rd_q[i] == pipe_rd) ||
             (exc_valid && rd_q[i] == RSTATUS))
            live_k[i] = 1'b0;
      end

      head_live = !fifo_empty && live_k[head_q];
      head_dead = !fifo_empty && !live_k[head_q];
      bypass    = !pipe_wr && fifo_empty && md_valid && (md_rd != 5'd0);
      md_drop   = (md_rd == 5'd0) || (pipe_wr && md_rd == pipe_rd);
      push      = md_fire && !bypass && !md_drop;
      // Dead heads drain regardless of who owns the main port.
      pop       = head_dead || (head_live && !pipe_wr);

      we_d    = 1'b0;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      if (pipe_wr) begin
         we_d    = 1'b1;
         wreg_d  = pipe_rd;
         wdata_d = pipe_data;
      end else if (head_live) begin
         we_d    = 1'b1;
         wreg_d  = rd_q[head_q];
         wdata_d = dat_q[head_q];
      end else if (bypass) begin
         we_d    = 1'b1;
         wreg_d  = md_rd;
         wdata_d = md_data;
      end

      rsd_d = exc_valid ? exc_code : rsd_q;

      // Push and pop never share a slot: push needs not-full, pop not-empty.
      live_d = live_k;
      if (pop)  live_d[head_q] = 1'b0;
      if (push) live_d[tail_q] = 1'b1;

      head_d  = head_q + AW'(pop);
      tail_d  = tail_q + AW'(push);
      count_d = count_q + CW'(push) - CW'(pop);

      pm_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_n = (push && tail_q == AW'(i)) ? md_rd : rd_q[i];
         if (live_d[i]) pm_d = pm_d | (32'd1 << rd_n);
      end
      pm_d[0] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (!ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]  <= '0;
            dat_q[i] <= '0;
         end
         live_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         we_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
         rs_q    <= 1'b0;
         rsd_q   <= '0;
         pm_q    <= '0;
      end else begin
         if (push) begin
            rd_q[tail_q]  <= md_rd;
            dat_q[tail_q] <= md_data;
         end
         live_q  <= live_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         we_q    <= we_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         rs_q    <= exc_valid;
         rsd_q   <= rsd_d;
         pm_q    <= pm_d;
      end
   end

   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wreg_q;
   assign data_writeReg    = wdata_q;
   assign rs_write         = rs_q;
   assign rs_writeData     = rsd_q;
   assign pending_mask     = pm_q;

endmodule
